// File: rtl/useq_pkg.sv
// Shared definitions for the microsequencer: sequencing ops, microword layout,
// control-word bit positions and fixed entry points (IRQ entry is used only with USEQ_IRQ_EN).
package useq_pkg;

    typedef enum logic [2:0] {
        SEQ_NEXT   = 3'd0,
        SEQ_FETCH  = 3'd1,
        SEQ_DISP1  = 3'd2,
        SEQ_DISP2  = 3'd3,
        SEQ_JUMP   = 3'd4,
        SEQ_BRCOND = 3'd5
    } seq_e;

    // Microword layout, LSB first: seq, wait, halt, target, ctrl.
    localparam int SEQ_LSB  = 0;
    localparam int SEQ_W    = 3;
    localparam int WAIT_BIT = 3;
    localparam int HALT_BIT = 4;
    localparam int TGT_LSB  = 5;

    localparam int ILL_UADDR = 62;
    localparam int IRQ_UADDR = 48;

    localparam int C_PC_INC   = 0;
    localparam int C_IR_LD    = 1;
    localparam int C_MEM_RD   = 2;
    localparam int C_MEM_WR   = 3;
    localparam int C_REG_WR   = 4;
    localparam int C_ALU_ADD  = 5;
    localparam int C_ALU_SUB  = 6;
    localparam int C_ALU_AND  = 7;
    localparam int C_ALU_OR   = 8;
    localparam int C_ADDR_LD  = 9;
    localparam int C_PC_LD    = 10;
    localparam int C_HALT_ACK = 11;
    localparam int C_IRQ_SAVE = 12;

    function automatic int mw_width(input int uaddr_w, input int ctrl_w);
        return TGT_LSB + uaddr_w + ctrl_w;
    endfunction

endpackage

// File: rtl/useq_rom.sv
// Combinational microcode store: microword for the current micro-PC plus the
// opcode and func dispatch targets (an unmapped entry yields ILL_UADDR).
module useq_rom
    import useq_pkg::*;
#(
    parameter int UADDR_W = 6,
    parameter int CTRL_W  = 24,
    parameter int MW_W    = mw_width(UADDR_W, CTRL_W)
) (
    input  logic [UADDR_W-1:0] i_upc,
    input  logic [3:0]         i_opcode,
    input  logic [5:0]         i_func,
    output logic [MW_W-1:0]    o_word,
    output logic [UADDR_W-1:0] o_disp1,
    output logic [UADDR_W-1:0] o_disp2
);

    logic [CTRL_W-1:0]  w_ctrl;
    logic [UADDR_W-1:0] w_tgt;
    seq_e               w_seq;
    logic               w_wait;
    logic               w_halt;

    function automatic logic [CTRL_W-1:0] cb(input int bit_idx);
        return CTRL_W'(1) << bit_idx;
    endfunction

    // Unused microstates jump to the illegal trap so a stray upc cannot run wild.
    always_comb begin
        w_ctrl = '0;
        w_seq  = SEQ_JUMP;
        w_wait = 1'b0;
        w_halt = 1'b0;
        w_tgt  = UADDR_W'(ILL_UADDR);
        case (int'(i_upc))
            0:  begin w_ctrl = cb(C_PC_INC) | cb(C_IR_LD) | cb(C_MEM_RD); w_seq = SEQ_NEXT; w_wait = 1'b1; end
            1:  w_seq = SEQ_DISP1;
            2:  w_seq = SEQ_DISP2;
            3:  w_seq = SEQ_DISP2;
            4:  begin w_ctrl = cb(C_ALU_ADD) | cb(C_REG_WR); w_seq = SEQ_FETCH; end
            5:  begin w_ctrl = cb(C_ALU_SUB) | cb(C_REG_WR); w_seq = SEQ_FETCH; end
            6:  begin w_ctrl = cb(C_ALU_AND) | cb(C_REG_WR); w_seq = SEQ_FETCH; end
            7:  begin w_ctrl = cb(C_ALU_OR)  | cb(C_REG_WR); w_seq = SEQ_FETCH; end
            8:  begin w_ctrl = cb(C_ALU_ADD) | cb(C_ADDR_LD); w_seq = SEQ_NEXT; end
            9:  begin w_ctrl = cb(C_MEM_RD); w_seq = SEQ_NEXT; w_wait = 1'b1; end
            10: begin w_ctrl = cb(C_REG_WR); w_seq = SEQ_FETCH; end
            12: begin w_ctrl = cb(C_ALU_ADD) | cb(C_ADDR_LD); w_seq = SEQ_NEXT; end
            13: begin w_ctrl = cb(C_MEM_WR); w_seq = SEQ_FETCH; w_wait = 1'b1; end
            16: begin w_ctrl = cb(C_ALU_SUB); w_seq = SEQ_BRCOND; w_tgt = UADDR_W'(18); end
            17: w_seq = SEQ_FETCH;
            18: begin w_ctrl = cb(C_PC_LD); w_seq = SEQ_FETCH; end
            20: begin w_ctrl = cb(C_PC_LD); w_seq = SEQ_FETCH; end
            24: begin w_ctrl = cb(C_HALT_ACK); w_seq = SEQ_FETCH; w_wait = 1'b1; w_halt = 1'b1; end
            48: begin w_ctrl = cb(C_IRQ_SAVE) | cb(C_PC_LD); w_seq = SEQ_NEXT; end
            // IRQ exit jumps rather than fetches so the service is not counted as a retired instruction.
            49: begin w_seq = SEQ_JUMP; w_tgt = '0; end
            62: w_seq = SEQ_JUMP;
            63: w_seq = SEQ_NEXT;
            default: ;
        endcase
    end

    assign o_word = {w_ctrl, w_tgt, w_halt, w_wait, w_seq};

    always_comb begin
        o_disp1 = UADDR_W'(ILL_UADDR);
        case (i_opcode)
            4'd0:  o_disp1 = UADDR_W'(2);
            4'd1:  o_disp1 = UADDR_W'(20);
            4'd4:  o_disp1 = UADDR_W'(16);
            4'd7:  o_disp1 = UADDR_W'(8);
            4'd8:  o_disp1 = UADDR_W'(12);
            4'd13: o_disp1 = UADDR_W'(63);
            4'd14: o_disp1 = UADDR_W'(24);
            4'd15: o_disp1 = UADDR_W'(3);
            default: ;
        endcase
    end

    always_comb begin
        o_disp2 = UADDR_W'(ILL_UADDR);
        case (i_func)
            6'd0:  o_disp2 = UADDR_W'(4);
            6'd1:  o_disp2 = UADDR_W'(5);
            6'd2:  o_disp2 = UADDR_W'(6);
            6'd3:  o_disp2 = UADDR_W'(7);
            6'd62: o_disp2 = UADDR_W'(24);
            default: ;
        endcase
    end

endmodule

// File: rtl/useq_controller.sv
// Microprogram sequencer with wait/halt handling, sticky flags and retired-instruction counter.
// Define USEQ_IRQ_EN to add the irq/irq_ack interrupt entry at FETCH.
module useq_controller
    import useq_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int UADDR_W   = 6,
    parameter int CTRL_W    = 24,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] inst,
    input  logic                 mem_ready,
    input  logic                 cond,
`ifdef USEQ_IRQ_EN
    input  logic                 irq,
    output logic                 irq_ack,
`endif
    output logic [CTRL_W-1:0]    ctrl,
    output logic [UADDR_W-1:0]   upc,
    output logic                 halted,
    output logic                 illegal,
    output logic [CNT_W-1:0]     retired
);

    localparam int MW_W = mw_width(UADDR_W, CTRL_W);

    logic [UADDR_W-1:0] r_upc;
    logic               r_halted;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_retired;

    logic [MW_W-1:0]    w_word;
    logic [UADDR_W-1:0] w_disp1;
    logic [UADDR_W-1:0] w_disp2;
    logic [UADDR_W-1:0] w_tgt;
    logic [UADDR_W-1:0] w_upc_inc;
    logic [UADDR_W-1:0] w_next;
    seq_e               w_seq;
    logic               w_wait;
    logic               w_halt;
    logic               w_stall;
    logic               w_fetch;
    logic               w_miss;
    logic               w_unused_inst;

    useq_rom #(.UADDR_W(UADDR_W), .CTRL_W(CTRL_W), .MW_W(MW_W)) u_rom (
        .i_upc    (r_upc),
        .i_opcode (inst[15:12]),
        .i_func   (inst[5:0]),
        .o_word   (w_word),
        .o_disp1  (w_disp1),
        .o_disp2  (w_disp2)
    );

    assign w_seq         = seq_e'(w_word[SEQ_LSB +: SEQ_W]);
    assign w_wait        = w_word[WAIT_BIT];
    assign w_halt        = w_word[HALT_BIT];
    assign w_tgt         = w_word[TGT_LSB +: UADDR_W];
    assign w_upc_inc     = r_upc + UADDR_W'(1);
    assign w_stall       = w_wait && !mem_ready;
    assign w_fetch       = (w_seq == SEQ_FETCH);
    assign w_unused_inst = ^inst;

    always_comb begin
        w_next = w_upc_inc;
        w_miss = 1'b0;
        case (w_seq)
            SEQ_NEXT: w_next = w_upc_inc;
            SEQ_FETCH: begin
`ifdef USEQ_IRQ_EN
                w_next = irq ? UADDR_W'(IRQ_UADDR) : '0;
`else
                w_next = '0;
`endif
            end
            SEQ_DISP1: begin
                w_next = w_disp1;
                w_miss = (w_disp1 == UADDR_W'(ILL_UADDR));
            end
            SEQ_DISP2: begin
                w_next = w_disp2;
                w_miss = (w_disp2 == UADDR_W'(ILL_UADDR));
            end
            SEQ_JUMP:   w_next = w_tgt;
            SEQ_BRCOND: w_next = cond ? w_tgt : w_upc_inc;
            default:    w_next = w_upc_inc;
        endcase
    end

    // Wait outranks halt: a halting microword only takes effect once its access completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_upc     <= '0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_retired <= '0;
`ifdef USEQ_IRQ_EN
            irq_ack   <= 1'b0;
`endif
        end else begin
`ifdef USEQ_IRQ_EN
            irq_ack <= 1'b0;
`endif
            if (!r_halted && !w_stall) begin
                if (w_halt) begin
                    r_halted <= 1'b1;
                end else begin
                    r_upc <= w_next;
                    if (w_miss) r_illegal <= 1'b1;
                    if (w_fetch) begin
                        r_retired <= r_retired + CNT_W'(1);
`ifdef USEQ_IRQ_EN
                        irq_ack   <= irq;
`endif
                    end
                end
            end
        end
    end

    assign ctrl    = w_word[TGT_LSB + UADDR_W +: CTRL_W];
    assign upc     = r_upc;
    assign halted  = r_halted;
    assign illegal = r_illegal;
    assign retired = r_retired;

endmodule

// File: tb/tb_useq_controller.sv
// Self-checking bench for useq_controller: directed scenarios plus randomized
// instruction streams compared cycle by cycle against a behavioural model.
module tb_useq_controller;

    localparam int CNT_W = 4;
    localparam int NU    = 64;
    localparam int ILL   = 62;
    localparam int IRQ_A = 48;
    localparam int K_NEXT = 0, K_FETCH = 1, K_DISP1 = 2, K_DISP2 = 3, K_JUMP = 4, K_BR = 5;
`ifdef USEQ_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [15:0]       inst;
    logic              mem_ready;
    logic              cond;
    logic              irq;
    logic [23:0]       ctrl;
    logic [5:0]        upc;
    logic              halted;
    logic              illegal;
    logic [CNT_W-1:0]  retired;
`ifdef USEQ_IRQ_EN
    logic              irq_ack;
`endif

    useq_controller #(.WORD_SIZE(16), .UADDR_W(6), .CTRL_W(24), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .inst      (inst),
        .mem_ready (mem_ready),
        .cond      (cond),
`ifdef USEQ_IRQ_EN
        .irq       (irq),
        .irq_ack   (irq_ack),
`endif
        .ctrl      (ctrl),
        .upc       (upc),
        .halted    (halted),
        .illegal   (illegal),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    // Microprogram description: sequencing kind, wait, halt, target per microstate.
    int t_seq [NU];
    int t_tgt [NU];
    bit t_wait[NU];
    bit t_halt[NU];
    int op_tab[16];
    int fn_tab[64];

    int m_upc, m_ret;
    bit m_halted, m_ill, m_ack;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_mw(input int a, input int s, input bit w, input bit h, input int t);
        t_seq[a] = s; t_wait[a] = w; t_halt[a] = h; t_tgt[a] = t;
    endtask

    task automatic init_tables();
        for (int i = 0; i < NU; i++) set_mw(i, K_JUMP, 1'b0, 1'b0, ILL);
        for (int i = 0; i < 16; i++) op_tab[i] = -1;
        for (int i = 0; i < 64; i++) fn_tab[i] = -1;
        set_mw(0, K_NEXT, 1, 0, 0);   set_mw(1, K_DISP1, 0, 0, 0);
        set_mw(2, K_DISP2, 0, 0, 0);  set_mw(3, K_DISP2, 0, 0, 0);
        for (int i = 4; i < 8; i++) set_mw(i, K_FETCH, 0, 0, 0);
        set_mw(8, K_NEXT, 0, 0, 0);   set_mw(9, K_NEXT, 1, 0, 0);  set_mw(10, K_FETCH, 0, 0, 0);
        set_mw(12, K_NEXT, 0, 0, 0);  set_mw(13, K_FETCH, 1, 0, 0);
        set_mw(16, K_BR, 0, 0, 18);   set_mw(17, K_FETCH, 0, 0, 0); set_mw(18, K_FETCH, 0, 0, 0);
        set_mw(20, K_FETCH, 0, 0, 0); set_mw(24, K_FETCH, 1, 1, 0);
        set_mw(48, K_NEXT, 0, 0, 0);  set_mw(49, K_JUMP, 0, 0, 0);
        set_mw(62, K_JUMP, 0, 0, 62); set_mw(63, K_NEXT, 0, 0, 0);
        op_tab[0] = 2;  op_tab[1] = 20; op_tab[4] = 16; op_tab[7] = 8;
        op_tab[8] = 12; op_tab[13] = 63; op_tab[14] = 24; op_tab[15] = 3;
        fn_tab[0] = 4; fn_tab[1] = 5; fn_tab[2] = 6; fn_tab[3] = 7; fn_tab[62] = 24;
    endtask

    task automatic model_reset();
        m_upc = 0; m_ret = 0; m_halted = 1'b0; m_ill = 1'b0; m_ack = 1'b0;
    endtask

    task automatic model_step(input logic [15:0] ins, input logic mr, input logic c);
        int t;
        m_ack = 1'b0;
        if (m_halted) return;
        if (t_wait[m_upc] && !mr) return;
        if (t_halt[m_upc]) begin
            m_halted = 1'b1;
            return;
        end
        case (t_seq[m_upc])
            K_NEXT: m_upc = (m_upc + 1) % NU;
            K_FETCH: begin
                m_ret = (m_ret + 1) % (1 << CNT_W);
                if (IRQ_ON && irq) begin
                    m_upc = IRQ_A;
                    m_ack = 1'b1;
                end else begin
                    m_upc = 0;
                end
            end
            K_DISP1, K_DISP2: begin
                t = (t_seq[m_upc] == K_DISP1) ? op_tab[ins[15:12]] : fn_tab[ins[5:0]];
                if (t < 0) begin
                    m_upc = ILL;
                    m_ill = 1'b1;
                end else begin
                    m_upc = t;
                end
            end
            K_JUMP: m_upc = t_tgt[m_upc];
            K_BR:   m_upc = c ? t_tgt[m_upc] : (m_upc + 1) % NU;
            default: m_upc = (m_upc + 1) % NU;
        endcase
    endtask

    task automatic step(input logic [15:0] i_ins, input logic i_mr, input logic i_c, input logic i_q);
        inst = i_ins; mem_ready = i_mr; cond = i_c; irq = i_q;
        model_step(i_ins, i_mr, i_c);
        @(posedge clk);
        #1;
        chk("upc", 32'(upc), 32'(m_upc));
        chk("retired", 32'(retired), 32'(m_ret));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("illegal", 32'(illegal), 32'(m_ill));
`ifdef USEQ_IRQ_EN
        chk("irq_ack", 32'(irq_ack), 32'(m_ack));
`endif
    endtask

    // Asynchronous reset: outputs must clear before any clock edge arrives.
    task automatic apply_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_upc", 32'(upc), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_ctrl", 32'(ctrl), 32'h7);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic alu_instr(input logic q_last);
        step(16'h0001, 1'b1, 1'b0, 1'b0);
        step(16'h0001, 1'b1, 1'b0, 1'b0);
        step(16'h0001, 1'b1, 1'b0, 1'b0);
        step(16'h0001, 1'b1, 1'b0, q_last);
    endtask

    function automatic logic [15:0] rand_inst();
        int ops[7];
        logic [3:0] op;
        logic [5:0] fn;
        ops = '{0, 1, 4, 7, 8, 13, 15};
        op = 4'(ops[$urandom_range(0, 6)]);
        fn = 6'($urandom_range(0, 3));
        return {op, 6'd0, fn};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        init_tables();
        reset = 1'b1; inst = '0; mem_ready = 1'b0; cond = 1'b0; irq = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("init_upc", 32'(upc), 32'd0);
        chk("init_ctrl", 32'(ctrl), 32'h7);
        reset = 1'b0;

        // Reach upc=5 with retired=7, then reset asynchronously.
        for (int i = 0; i < 7; i++) alu_instr(1'b0);
        step(16'h0001, 1'b1, 1'b0, 1'b0);
        step(16'h0001, 1'b1, 1'b0, 1'b0);
        step(16'h0001, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_upc", 32'(upc), 32'd5);
        chk("pre_rst_retired", 32'(retired), 32'd7);
        apply_reset();

        // Load word with a three-cycle memory stall.
        step(16'h7000, 1'b1, 1'b0, 1'b0);
        step(16'h7000, 1'b1, 1'b0, 1'b0);
        step(16'h7000, 1'b1, 1'b0, 1'b0);
        chk("lw_ctrl", 32'(ctrl), 32'h4);
        for (int i = 0; i < 3; i++) begin
            step(16'h7000, 1'b0, 1'b0, 1'b0);
            chk("lw_wait_upc", 32'(upc), 32'd9);
            chk("lw_wait_retired", 32'(retired), 32'd0);
        end
        step(16'h7000, 1'b1, 1'b0, 1'b0);
        step(16'h7000, 1'b1, 1'b0, 1'b0);
        chk("lw_retired", 32'(retired), 32'd1);
        chk("lw_upc", 32'(upc), 32'd0);

        // Randomized legal instruction stream.
        for (int i = 0; i < 600; i++)
            step(rand_inst(), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0));

        // Unmapped func on opcode 15.
        apply_reset();
        step(16'hF03F, 1'b1, 1'b0, 1'b0);
        step(16'hF03F, 1'b1, 1'b0, 1'b0);
        step(16'hF03F, 1'b1, 1'b0, 1'b0);
        chk("ill_upc", 32'(upc), 32'(ILL));
        chk("ill_flag", 32'(illegal), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(rand_inst(), 1'b1, 1'b0, 1'b0);
            chk("ill_sticky", 32'(illegal), 32'd1);
        end

        // Halt on a wait word: stall first, then halt and freeze.
        apply_reset();
        step(16'hE000, 1'b1, 1'b0, 1'b0);
        step(16'hE000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(16'hE000, 1'b0, 1'b0, 1'b0);
            chk("hlt_wait_halted", 32'(halted), 32'd0);
            chk("hlt_wait_upc", 32'(upc), 32'd24);
        end
        step(16'hE000, 1'b1, 1'b0, 1'b0);
        chk("hlt_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step(rand_inst(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            chk("hlt_frozen_upc", 32'(upc), 32'd24);
            chk("hlt_frozen_retired", 32'(retired), 32'd0);
        end

        // SEQ from the last microstate wraps to 0.
        apply_reset();
        step(16'hD000, 1'b1, 1'b0, 1'b0);
        step(16'hD000, 1'b1, 1'b0, 1'b0);
        chk("wrap_at_63", 32'(upc), 32'd63);
        step(16'hD000, 1'b1, 1'b0, 1'b0);
        chk("wrap_upc", 32'(upc), 32'd0);

        // Retired counter wraps after 2^CNT_W instructions.
        apply_reset();
        for (int i = 0; i < 15; i++) alu_instr(1'b0);
        chk("ret_15", 32'(retired), 32'd15);
        alu_instr(1'b0);
        chk("ret_wrap", 32'(retired), 32'd0);

`ifdef USEQ_IRQ_EN
        // Interrupt taken at the FETCH of instruction 3.
        apply_reset();
        alu_instr(1'b0);
        alu_instr(1'b0);
        alu_instr(1'b1);
        chk("irq_upc", 32'(upc), 32'(IRQ_A));
        chk("irq_ack_hi", 32'(irq_ack), 32'd1);
        chk("irq_retired", 32'(retired), 32'd3);
        step(16'h0001, 1'b1, 1'b0, 1'b0);
        chk("irq_ack_lo", 32'(irq_ack), 32'd0);
        step(16'h0001, 1'b1, 1'b0, 1'b0);
        chk("irq_exit_upc", 32'(upc), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/useq_controller.md
USEQ_CONTROLLER -- requirements
Module: useq_controller

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 16, meaning instruction width.
REQ-002 The block SHALL have parameter UADDR_W, default 6, meaning micro-PC width (64 microstates).
REQ-003 The block SHALL have parameter CTRL_W, default 24, meaning datapath control-word width.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning retired-instruction counter width.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 inst  input  WORD_SIZE  current instruction register; opcode inst[15:12], func inst[5:0].
REQ-008 mem_ready  input  1  memory handshake; high when the current memory access completes.
REQ-009 cond  input  1  datapath branch condition for conditional microbranches.
REQ-010 ctrl  output  CTRL_W  control word for the current microstate.
REQ-011 upc  output  UADDR_W  current micro-PC.
REQ-012 halted  output  1  sticky halt flag.
REQ-013 illegal  output  1  sticky undefined-instruction flag.
REQ-014 retired  output  CNT_W  count of completed instructions.

Function
REQ-015 Each microword SHALL hold ctrl, a 3-bit seq field, a wait bit, a halt bit and a UADDR_W-bit target.
REQ-016 ctrl SHALL be a combinational ROM lookup of upc; every other state SHALL be registered.
REQ-017 seq encodings SHALL be: SEQ (upc+1), FETCH (0), DISP1 (opcode table), DISP2 (func table), JUMP (target), BRCOND (target if cond else upc+1).
REQ-018 If the wait bit is set and mem_ready is low, upc SHALL hold and seq SHALL be ignored that cycle.
REQ-019 Wait SHALL take priority over halt, dispatch and all other sequencing in the same cycle.
REQ-020 SEQ at upc = 2^UADDR_W-1 SHALL wrap to 0.
REQ-021 A DISP1/DISP2 lookup with no table entry SHALL go to ILL_UADDR and set illegal the next cycle.
REQ-022 A microword with the halt bit, not stalled by wait, SHALL set halted and freeze upc and retired until reset.
REQ-023 retired SHALL increment by 1 on each non-stalled FETCH transition, wrapping modulo 2^CNT_W.
REQ-024 Dispatch latency SHALL be one cycle: inst sampled at edge N selects upc valid after edge N.

Reset
REQ-025 While reset is high: upc=0, halted=0, illegal=0, retired=0, and ctrl=ROM[0] (fetch word), all immediately and independent of clk.
REQ-026 Reset asserted mid-instruction or mid-wait SHALL abandon the sequence; execution restarts at upc 0 on the first edge after deassertion.

Configuration
REQ-027 Macro USEQ_IRQ_EN SHALL add input irq and output irq_ack (both 1 bit).
REQ-028 With USEQ_IRQ_EN defined, a non-stalled FETCH transition with irq high SHALL go to IRQ_UADDR instead of 0, pulse irq_ack for one cycle, and still increment retired.
REQ-029 Without USEQ_IRQ_EN, the irq and irq_ack ports and their logic SHALL be absent, and FETCH SHALL always go to 0.
REQ-030 A halted controller SHALL ignore irq.

Structure
REQ-031 Package useq_pkg SHALL hold the seq encodings, microword field offsets, and the ILL_UADDR and IRQ_UADDR constants.
REQ-032 The microcode ROM and both dispatch tables SHALL be in one combinational sub-module, useq_rom, with upc, opcode and func as inputs and the microword plus the two dispatch targets as outputs.
REQ-033 useq_controller SHALL contain only the sequencer, wait/halt logic, flags and counter.

Verification
REQ-034 Reset pulse with upc=5 and retired=7 -> upc=0, retired=0, flags=0 immediately, before any clk edge.
REQ-035 Load word (opcode 7) with mem_ready low for 3 cycles -> upc holds 3 cycles at the wait state; retired increments by exactly 1 after completion.
REQ-036 Opcode 15 with func 63 unmapped -> upc=ILL_UADDR one cycle after dispatch; illegal=1 and stays 1 until reset.
REQ-037 HLT microword coincident with mem_ready=0 on a wait word -> no halt until mem_ready=1; then halted=1 and upc/retired frozen for 10 cycles.
REQ-038 With UADDR_W=6, SEQ from upc 63 -> upc=0; with CNT_W=4, 16 retired instructions -> retired=0.
REQ-039 With USEQ_IRQ_EN defined, irq=1 at the FETCH of instruction 3 -> upc=IRQ_UADDR, irq_ack high for exactly 1 cycle, retired=3.
